// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//   RV32I fetch stage. Holds the fetch PC, issues word requests to
//   instruction memory over a valid/ready handshake, buffers returned words
//   in an in-order prefetch FIFO and presents one instruction per cycle to
//   the decoder. Handles downstream stall, redirects and fetch faults.
//
// Parameters
//   RESET_PC    PC loaded on reset (4-byte aligned)
//   FIFO_DEPTH  prefetch entries (power of two, >= 2)
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   imem_req_valid/ready/addr      fetch request channel
//   imem_resp_valid/data/err       in-order response channel
//   redirect_valid/pc              flush and restart fetch at redirect_pc
//   stall                          downstream not accepting this cycle
//   inst_valid/code/pc             head instruction to the decoder
//   fetch_fault/fault_pc           sticky fault flag and faulting PC
//   perf_retired/perf_flushed      performance counters (optional)
//
// Optional feature
//   IFU_PERF_CNT_EN  adds perf_retired / perf_flushed counters
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        imem_resp_err,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output logic        inst_valid,
   output logic [31:0] inst_code,
   output logic [31:0] inst_pc,
   output logic        fetch_fault,
   output logic [31:0] fault_pc
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [31:0] perf_retired,
   output logic [31:0] perf_flushed
`endif
);

   // state   | meaning
   // --------+-----------------------------------------------------------
   // S_RUN   | fetching; head instructions delivered to the decoder
   // S_FAULT | fetch halted after bus error or misaligned redirect;
   //         | left only by an aligned redirect

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);

   typedef enum logic {
      S_RUN   = 1'b0,
      S_FAULT = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [31:0]     pc_q, pc_d;
   logic [31:0]     resp_pc_q, resp_pc_d;
   logic [CW-1:0]   out_q, out_d;
   logic [CW-1:0]   disc_q, disc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic            fault_q, fault_d;
   logic [31:0]     fault_pc_q, fault_pc_d;

   logic [31:0]     mem_data_q [FIFO_DEPTH];
   logic            mem_err_q  [FIFO_DEPTH];
   logic [31:0]     mem_pc_q   [FIFO_DEPTH];

   logic running, not_empty, head_err, credit_ok;
   logic req_valid_int, accept, resp_fire, drop, push, head_ok, pop;
   logic redirect_misaligned;

   always_comb begin
      running             = (state_q == S_RUN);
      not_empty           = (cnt_q != '0);
      head_err            = mem_err_q[rd_ptr_q];
      // Outstanding includes responses still to be discarded, so the FIFO
      // can never be overrun by in-flight data.
      credit_ok           = ({1'b0, cnt_q} + {1'b0, out_q}) < DEPTH_L;
      req_valid_int       = running && !redirect_valid && credit_ok;
      accept              = req_valid_int && imem_req_ready;
      resp_fire           = imem_resp_valid && (out_q != '0);
      drop                = resp_fire && (redirect_valid || (disc_q != '0));
      push                = resp_fire && !drop;
      head_ok             = not_empty && !head_err && running;
      pop                 = head_ok && !stall && !redirect_valid;
      redirect_misaligned = (redirect_pc[1:0] != 2'b00);
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = accept ? pc_q + 32'd4 : pc_q;
      resp_pc_d  = resp_pc_q;
      out_d      = out_q + CW'(accept) - CW'(resp_fire);
      disc_d     = disc_q;
      cnt_d      = cnt_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fault_d    = fault_q;
      fault_pc_d = fault_pc_q;

      if (redirect_valid) begin
         pc_d      = redirect_pc;
         resp_pc_d = redirect_pc;
         // Everything still in flight after this cycle belongs to the old path.
         disc_d    = out_q - CW'(resp_fire);
         cnt_d     = '0;
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         if (redirect_misaligned) begin
            state_d    = S_FAULT;
            fault_d    = 1'b1;
            fault_pc_d = redirect_pc;
         end else begin
            state_d    = S_RUN;
            fault_d    = 1'b0;
            fault_pc_d = 32'h0;
         end
      end else begin
         if (drop) begin
            disc_d = disc_q - CW'(1);
         end
         if (push) begin
            wr_ptr_d  = wr_ptr_q + AW'(1);
            resp_pc_d = resp_pc_q + 32'd4;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         cnt_d = cnt_q + CW'(push) - CW'(pop);
         if (running && not_empty && head_err) begin
            state_d    = S_FAULT;
            fault_d    = 1'b1;
            fault_pc_d = mem_pc_q[rd_ptr_q];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_RUN;
         pc_q       <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         out_q      <= '0;
         disc_q     <= '0;
         cnt_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fault_q    <= 1'b0;
         fault_pc_q <= 32'h0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         resp_pc_q  <= resp_pc_d;
         out_q      <= out_d;
         disc_q     <= disc_d;
         cnt_q      <= cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fault_q    <= fault_d;
         fault_pc_q <= fault_pc_d;
      end
   end

   // Storage carries no reset; validity is tracked by the pointers/count.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem_data_q[wr_ptr_q] <= imem_resp_data;
         mem_err_q[wr_ptr_q]  <= imem_resp_err;
         mem_pc_q[wr_ptr_q]   <= resp_pc_q;
      end
   end

   // Outputs are forced low while rst is high, including the first reset cycle.
   always_comb begin
      imem_req_valid = !rst && req_valid_int;
      imem_req_addr  = pc_q;
      inst_valid     = !rst && head_ok;
      inst_code      = inst_valid ? mem_data_q[rd_ptr_q] : 32'h0;
      inst_pc        = inst_valid ? mem_pc_q[rd_ptr_q]   : 32'h0;
      fetch_fault    = !rst && fault_q;
      fault_pc       = rst ? 32'h0 : fault_pc_q;
   end

`ifdef IFU_PERF_CNT_EN
   logic [31:0] perf_retired_q;
   logic [31:0] perf_flushed_q;
   logic [31:0] flush_inc;

   always_comb begin
      flush_inc = 32'(drop);
      if (redirect_valid) begin
         flush_inc = flush_inc + 32'(cnt_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_retired_q <= 32'h0;
         perf_flushed_q <= 32'h0;
      end else begin
         perf_retired_q <= perf_retired_q + 32'(pop);
         perf_flushed_q <= perf_flushed_q + flush_inc;
      end
   end

   assign perf_retired = perf_retired_q;
   assign perf_flushed = perf_flushed_q;
`endif

endmodule
